tdc_stim_gen: RTL
=================

// Module: tdc_stim_gen
// PURPOSE
//  Start/stop edge-pair generator: the stimulus end of the ring-oscillator TDC interface.
//  Emits start/stop pulse pairs separated by a programmed number of clk cycles.
//  After each pair it waits for the TDC result handshake before launching the next pair.
//  Drives digital-domain calibration and linearity sweeps of the TDC (known coarse interval in, code out).
// PARAMETERS
//  DLY_W    16  width of cfg_delay (start-rise to stop-rise interval, clk cycles)
//  PW_W      8  width of cfg_pw (start/stop pulse width, clk cycles)
//  CNT_W    16  width of cfg_count and pair_idx (pairs per burst)
//  GAP_W    16  width of cfg_gap (idle clk cycles between pairs)
//  TO_W     16  width of cfg_timeout (result wait limit, clk cycles)
// PORTS
//  clk          in   1      FSM clock
//  rst          in   1      asynchronous reset, active-high
//  go           in   1      1-cycle request; sampled only in IDLE
//  abort        in   1      terminate burst; takes effect next cycle
//  cfg_delay    in   DLY_W  D: stop rises D cycles after start rises
//  cfg_pw       in   PW_W   PW: pulse width; 0 treated as 1
//  cfg_count    in   CNT_W  N: pairs per burst; 0 treated as 1
//  cfg_gap      in   GAP_W  G: idle cycles after each ack before next pair
//  cfg_timeout  in   TO_W   T: max cycles in WAIT_ACK; 0 = wait forever
//  tdc_valid    in   1      TDC result captured (1-cycle pulse from TDC FSM)
//  start        out  1      TDC start pulse (registered)
//  stop         out  1      TDC stop pulse (registered)
//  busy         out  1      high in every state except IDLE
//  done         out  1      1-cycle pulse when burst finishes or aborts
//  pair_idx     out  CNT_W  index of the current pair, 0..N-1
//  timeout_cnt  out  CNT_W  pairs in this burst that hit timeout (saturating)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, config registers 0.
//  Config is latched on the accepted go; cfg_* changes mid-burst are ignored.
//  States: IDLE -> PULSE -> WAIT_ACK -> GAP -> PULSE ... -> DONE -> IDLE.
//  IDLE
//   - go=1: latch config; clear pair_idx and timeout_cnt; go to PULSE.
//   - start rises the cycle after go.
//  PULSE
//   - Counter t runs from 0 to D+PW-1, one step per cycle.
//   - start = (t < PW); stop = (t >= D) && (t < D+PW); both registered, glitch-free.
//   - D=0: start and stop rise in the same cycle. D<PW: the two pulses overlap (legal).
//   - Exits to WAIT_ACK after t = D+PW-1; start and stop are 0 in WAIT_ACK.
//  WAIT_ACK
//   - tdc_valid=1: go to GAP.
//   - Timeout: T!=0 and T cycles elapse with no tdc_valid -> timeout_cnt += 1 (saturates), go to GAP.
//   - tdc_valid in the same cycle as timeout expiry counts as a valid ack (no timeout).
//   - tdc_valid outside WAIT_ACK is ignored.
//  GAP
//   - Waits G cycles (G=0: zero cycles, leaves next cycle).
//   - Then: if pair_idx == N-1, go to DONE; else pair_idx += 1 and go to PULSE.
//  DONE
//   - done=1 for exactly 1 cycle; busy=0 from the next cycle (IDLE).
//   - pair_idx and timeout_cnt hold until the next accepted go.
//  abort (any non-IDLE state)
//   - Next cycle: start=stop=0, go to DONE (done pulses once).
//   - abort in IDLE: no effect. abort and go in the same IDLE cycle: abort wins, go dropped.
//  go while busy is ignored.
//  rst asserted mid-burst: immediate return to reset values; no done pulse.
//  Arithmetic: D+PW evaluated at DLY_W+1 bits, so no wrap at maximum values.
// TESTING
//  1. Reset, then go with D=5, PW=2, N=1, G=0, T=0; ack 3 cycles after stop falls.
//     -> start high cycles 1-2 and stop high cycles 6-7 after go; done 1 cycle after ack+GAP; busy low afterwards.
//  2. D=0, PW=3 -> start and stop rise together and stay high 3 cycles.
//     D=1, PW=4 -> overlapping pulses with stop 1 cycle later.
//  3. N=4, G=10, immediate acks -> 4 pairs with stop-rise to next start-rise spacing constant.
//     pair_idx steps 0..3; timeout_cnt=0.
//  4. N=3, T=20, no tdc_valid -> each pair waits exactly 20 cycles; timeout_cnt=3; done pulses.
//     Repeat with tdc_valid coincident with expiry -> timeout_cnt=0.
//  5. abort during PULSE of pair 2 of N=5 -> start/stop 0 next cycle; single done pulse; pair_idx=1.
//     go during the burst is ignored.
//  6. rst asserted in WAIT_ACK -> all outputs 0 asynchronously; no done pulse.
//     Subsequent go starts a clean burst with pair_idx=0.

Source files
------------

// File: rtl/tdc_stim_gen_if.sv
// Control, configuration and TDC-handshake bundle for the start/stop pair generator.
// The master side drives requests, configuration and the TDC result strobe.
interface tdc_stim_gen_if #(
    parameter int DLY_W = 16,
    parameter int PW_W  = 8,
    parameter int CNT_W = 16,
    parameter int GAP_W = 16,
    parameter int TO_W  = 16
);
    logic             go;
    logic             abort;
    logic [DLY_W-1:0] cfg_delay;
    logic [PW_W-1:0]  cfg_pw;
    logic [CNT_W-1:0] cfg_count;
    logic [GAP_W-1:0] cfg_gap;
    logic [TO_W-1:0]  cfg_timeout;
    logic             tdc_valid;
    logic             start;
    logic             stop;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pair_idx;
    logic [CNT_W-1:0] timeout_cnt;

    modport master (
        output go, abort, cfg_delay, cfg_pw, cfg_count, cfg_gap, cfg_timeout, tdc_valid,
        input  start, stop, busy, done, pair_idx, timeout_cnt
    );

    modport slave (
        input  go, abort, cfg_delay, cfg_pw, cfg_count, cfg_gap, cfg_timeout, tdc_valid,
        output start, stop, busy, done, pair_idx, timeout_cnt
    );
endinterface

// File: rtl/tdc_stim_gen.sv
// Start/stop edge-pair generator for ring-oscillator TDC calibration: emits bursts of
// start/stop pulse pairs D clk cycles apart and waits for each TDC result (or timeout).
module tdc_stim_gen #(
    parameter int DLY_W = 16,
    parameter int PW_W  = 8,
    parameter int CNT_W = 16,
    parameter int GAP_W = 16,
    parameter int TO_W  = 16
) (
    input logic           clk,
    input logic           rst,
    tdc_stim_gen_if.slave bus
);
    // Wide enough that D+PW never wraps at maximum configuration values.
    localparam int SUM_W = ((DLY_W > PW_W) ? DLY_W : PW_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state;
    logic [SUM_W-1:0] t;
    logic [TO_W-1:0]  w;
    logic [GAP_W-1:0] g;

    logic [DLY_W-1:0] d_lat;
    logic [PW_W-1:0]  pw_lat;
    logic [CNT_W-1:0] n_lat;
    logic [GAP_W-1:0] g_lat;
    logic [TO_W-1:0]  to_lat;

    logic             start_r;
    logic             stop_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] pair_idx_r;
    logic [CNT_W-1:0] timeout_cnt_r;

    logic [SUM_W-1:0] end_t;
    logic [SUM_W-1:0] nt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic in_window(input logic [SUM_W-1:0] x,
                                       input logic [SUM_W-1:0] lo,
                                       input logic [SUM_W-1:0] len);
        return (x >= lo) && (x < lo + len);
    endfunction

    assign end_t = SUM_W'(d_lat) + SUM_W'(pw_lat) - SUM_W'(1);
    assign nt    = t + SUM_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            t             <= '0;
            w             <= '0;
            g             <= '0;
            d_lat         <= '0;
            pw_lat        <= '0;
            n_lat         <= '0;
            g_lat         <= '0;
            to_lat        <= '0;
            start_r       <= 1'b0;
            stop_r        <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            pair_idx_r    <= '0;
            timeout_cnt_r <= '0;
        end else begin
            done_r <= 1'b0;
            if (state == S_IDLE) begin
                // abort in the same cycle as go suppresses the launch
                if (bus.go && !bus.abort) begin
                    d_lat         <= bus.cfg_delay;
                    pw_lat        <= (bus.cfg_pw == '0) ? PW_W'(1) : bus.cfg_pw;
                    n_lat         <= (bus.cfg_count == '0) ? CNT_W'(1) : bus.cfg_count;
                    g_lat         <= bus.cfg_gap;
                    to_lat        <= bus.cfg_timeout;
                    pair_idx_r    <= '0;
                    timeout_cnt_r <= '0;
                    t             <= '0;
                    start_r       <= 1'b1;
                    stop_r        <= (bus.cfg_delay == '0);
                    busy_r        <= 1'b1;
                    state         <= S_PULSE;
                end
            end else if (state == S_DONE) begin
                busy_r <= 1'b0;
                state  <= S_IDLE;
            end else if (bus.abort) begin
                start_r <= 1'b0;
                stop_r  <= 1'b0;
                done_r  <= 1'b1;
                state   <= S_DONE;
            end else begin
                case (state)
                    S_PULSE: begin
                        // outputs are computed from the next t so they are register outputs
                        if (t == end_t) begin
                            start_r <= 1'b0;
                            stop_r  <= 1'b0;
                            w       <= '0;
                            state   <= S_WAIT;
                        end else begin
                            t       <= nt;
                            start_r <= in_window(nt, '0, SUM_W'(pw_lat));
                            stop_r  <= in_window(nt, SUM_W'(d_lat), SUM_W'(pw_lat));
                        end
                    end
                    S_WAIT: begin
                        if (bus.tdc_valid) begin
                            g     <= '0;
                            state <= S_GAP;
                        end else if ((to_lat != '0) && (w == to_lat - TO_W'(1))) begin
                            timeout_cnt_r <= sat_inc(timeout_cnt_r);
                            g             <= '0;
                            state         <= S_GAP;
                        end else begin
                            w <= w + TO_W'(1);
                        end
                    end
                    S_GAP: begin
                        // G=0 still spends this one decision cycle in GAP
                        if ((g_lat == '0) || (g == g_lat - GAP_W'(1))) begin
                            if (pair_idx_r == n_lat - CNT_W'(1)) begin
                                done_r <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                pair_idx_r <= pair_idx_r + CNT_W'(1);
                                t          <= '0;
                                start_r    <= 1'b1;
                                stop_r     <= (d_lat == '0);
                                state      <= S_PULSE;
                            end
                        end else begin
                            g <= g + GAP_W'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.start       = start_r;
    assign bus.stop        = stop_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.pair_idx    = pair_idx_r;
    assign bus.timeout_cnt = timeout_cnt_r;
endmodule
